writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage; sits directly upstream of the register file.
- Accepts completed results (destination, 64-bit data, ppp field-select code) from the memory stage over a valid/ready handshake.
- Buffers results in a 2-entry FIFO and drives the register-file write port with at most one write per cycle.
- Provides byte-merged forwarding of pending writes onto the register-file read data for operands rA/rB.
- Bit numbering is big-endian throughout ([0:63]; byte 0 = bits 0:7).

Parameters:
- DEPTH, 2, FIFO entries; legal values 2 or 4 (power of two).
- DATA_W, 64, datapath width; fixed at 64 (eight bytes).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; state clears on a rising clk edge when reset=0.
- in_valid  input  1  memory stage presents a result.
- in_ready  output  1  stage can accept; equals 1 when FIFO not full.
- in_wr  input  1  result writes a register; 0 = retire without write.
- in_rd_addr  input  [0:4]  destination register.
- in_rd_data  input  [0:63]  result data.
- in_ppp  input  [0:2]  field select.
- hold  input  1  downstream stall; suppresses the write this cycle.
- writeEnable  output  1  register-file write strobe.
- rD_address  output  [0:4]  write address.
- rD_data  output  [0:63]  write data.
- ppp  output  [0:2]  write field select.
- rA_address, rB_address  input  [0:4]  operand read addresses (shared with register file).
- rA_rf_data, rB_rf_data  input  [0:63]  raw register-file read data.
- rA_fwd_data, rB_fwd_data  output  [0:63]  forwarded operands.
- pending  output  1  FIFO non-empty.

Behaviour:
- Reset (reset=0 at an edge): FIFO empty, pointers 0; writeEnable=0, rD_address=0, rD_data=0, ppp=000, pending=0. An in-flight accepted entry is discarded.
- Accept: on an edge with in_valid & in_ready, the entry is enqueued.
  - Entries with in_wr=0, in_ppp in 101..111, or in_rd_addr=0 are consumed (handshake completes) but not enqueued.
- Write port: the head entry drives rD_address, rD_data and ppp combinationally from FIFO storage.
  - writeEnable = head valid & ~hold.
  - On an edge with writeEnable=1 the head is dequeued.
- Latency: an entry accepted at edge N into an empty FIFO gives writeEnable=1 during cycle N+1.
- in_ready is FIFO not full. It does not depend on dequeue in the same cycle (no same-cycle pass-through when full).
- Simultaneous enqueue and dequeue when non-empty: count unchanged, pointers both advance, no data lost.
- hold=1: head retained, writeEnable=0; enqueue continues until full.
- Pointer wrap: modulo DEPTH, with an extra wrap bit to distinguish full from empty.
- ppp byte masks (mask bit i covers byte i):
  - 000 -> 11111111
  - 001 -> 11110000 (bits 0:31)
  - 010 -> 00001111 (bits 32:63)
  - 011 -> 10101010 (bytes 0,2,4,6)
  - 100 -> 01010101 (bytes 1,3,5,7)
- Forwarding (combinational):
  - Start from rX_rf_data.
  - For each valid entry whose rd_addr equals rX_address, oldest to youngest, overwrite the masked bytes with the entry's data. The youngest entry wins on overlapping bytes.
  - rX_address=0 always yields rX_rf_data.
  - The head entry is forwarded even in the cycle it is being written.
- pending = count != 0.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined: forwarding as described.
- Undefined: rA_fwd_data=rA_rf_data and rB_fwd_data=rB_rf_data; no comparators or merge logic are built. The pipeline must instead stall issue while pending=1.

Decomposition:
- Shared package cpu_pkg:
  - PPP_FULL=000, PPP_UPPER=001, PPP_LOWER=010, PPP_EVEN=011, PPP_ODD=100.
  - ppp_to_mask function (3-bit code to 8-bit byte mask).
  - REG_ADDR_W=5, DATA_W=64.
- One sub-module: wb_byte_merge (base data, new data, 8-bit mask -> merged data), instantiated per entry per operand.

Test Plan:
- Basic write: in_valid=1, in_wr=1, addr=5, data=0x1122334455667788, ppp=000, hold=0 -> next cycle writeEnable=1, rD_address=5, rD_data=0x1122334455667788; pending returns to 0 after that edge.
- Backpressure/full: hold=1, push 2 entries (addr 3 then addr 4) -> in_ready=0 after the second accept and a third push is not accepted. Release hold -> writes to addr 3 then addr 4 on consecutive cycles; in_ready=1 after the first dequeue.
- Forward merge: pending ppp=011 to addr 7 data 0xAAAAAAAAAAAAAAAA (older), then ppp=001 to addr 7 data 0x1111111111111111; rA_rf_data=0; rA_address=7 -> rA_fwd_data=0x11111111AA00AA00.
- Drops: in_wr=0, ppp=110, or addr=0 each complete the handshake with no write ever issued -> writeEnable stays 0, pending=0.
- Reset mid-operation: 2 entries queued, reset=0 for one edge -> all outputs zero, in_ready=1, pending=0, no write of the discarded entries.
- Simultaneous push/pop: steady in_valid=1 with hold=0 over 6 results -> one write per cycle, order preserved, count never exceeds 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/data widths, ppp field-select codes and the
// ppp-to-byte-mask decode. Big-endian numbering: mask bit i covers data bits [8i:8i+7].
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int PPP_W      = 3;
  localparam int NBYTES     = DATA_W / 8;

  typedef enum logic [0:PPP_W-1] {
    PPP_FULL  = 3'b000,
    PPP_UPPER = 3'b001,
    PPP_LOWER = 3'b010,
    PPP_EVEN  = 3'b011,
    PPP_ODD   = 3'b100
  } ppp_e;

  typedef struct packed {
    logic [0:REG_ADDR_W-1] rd_addr;
    logic [0:DATA_W-1]     data;
    logic [0:PPP_W-1]      ppp;
  } wb_entry_t;

  function automatic logic [0:NBYTES-1] ppp_to_mask(input logic [0:PPP_W-1] code);
    case (code)
      PPP_FULL:  return 8'b1111_1111;
      PPP_UPPER: return 8'b1111_0000;
      PPP_LOWER: return 8'b0000_1111;
      PPP_EVEN:  return 8'b1010_1010;
      PPP_ODD:   return 8'b0101_0101;
      default:   return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic ppp_is_legal(input logic [0:PPP_W-1] code);
    return (code <= PPP_ODD);
  endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Byte-granular merge: each byte whose mask bit is set takes the new data,
// otherwise the base data passes through.
module wb_byte_merge
  import cpu_pkg::*;
(
  input  logic [0:DATA_W-1] i_base,
  input  logic [0:DATA_W-1] i_new,
  input  logic [0:NBYTES-1] i_mask,
  output logic [0:DATA_W-1] o_merged
);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign o_merged[gi*8 +: 8] = i_mask[gi] ? i_new[gi*8 +: 8] : i_base[gi*8 +: 8];
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: DEPTH-entry result FIFO feeding the register-file write port.
// Optional operand forwarding from pending entries is built only when WB_FORWARD_EN is defined.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wr,
  input  logic [0:REG_ADDR_W-1] in_rd_addr,
  input  logic [0:DATA_W-1]     in_rd_data,
  input  logic [0:PPP_W-1]      in_ppp,
  input  logic                  hold,
  output logic                  writeEnable,
  output logic [0:REG_ADDR_W-1] rD_address,
  output logic [0:DATA_W-1]     rD_data,
  output logic [0:PPP_W-1]      ppp,
  input  logic [0:REG_ADDR_W-1] rA_address,
  input  logic [0:REG_ADDR_W-1] rB_address,
  input  logic [0:DATA_W-1]     rA_rf_data,
  input  logic [0:DATA_W-1]     rB_rf_data,
  output logic [0:DATA_W-1]     rA_fwd_data,
  output logic [0:DATA_W-1]     rB_fwd_data,
  output logic                  pending
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W:0]   w_count;
  logic             w_full;
  logic             w_head_valid;
  logic             w_accept;
  logic             w_enq;
  wb_entry_t        w_head;
  wb_entry_t        w_new;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == (PTR_W+1)'(DEPTH));
  assign w_head_valid = (w_count != '0);

  // in_ready deliberately ignores a same-cycle dequeue to keep it off the hold path.
  assign in_ready = ~w_full;
  assign w_accept = in_valid & in_ready;
  assign w_enq    = w_accept & in_wr & ppp_is_legal(in_ppp) & (in_rd_addr != '0);
  assign w_new    = '{rd_addr: in_rd_addr, data: in_rd_data, ppp: in_ppp};

  assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign writeEnable = w_head_valid & ~hold;
  assign rD_address  = w_head_valid ? w_head.rd_addr : '0;
  assign rD_data     = w_head_valid ? w_head.data    : '0;
  assign ppp         = w_head_valid ? w_head.ppp     : '0;
  assign pending     = w_head_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (writeEnable) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_new;
  end

`ifdef WB_FORWARD_EN
  // Merge chain runs oldest to youngest so younger entries overwrite shared bytes.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
    localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
    logic [PTR_W-1:0]  w_idx;
    wb_entry_t         w_ent;
    logic              w_live;
    logic [0:NBYTES-1] w_mask;
    logic [0:NBYTES-1] w_a_mask;
    logic [0:NBYTES-1] w_b_mask;
    logic [0:DATA_W-1] w_a_base;
    logic [0:DATA_W-1] w_b_base;
    logic [0:DATA_W-1] w_a_out;
    logic [0:DATA_W-1] w_b_out;

    assign w_idx    = r_rd_ptr[PTR_W-1:0] + OFF;
    assign w_ent    = r_mem[w_idx];
    assign w_live   = ((PTR_W+1)'(gi) < w_count);
    assign w_mask   = ppp_to_mask(w_ent.ppp);
    assign w_a_mask = (w_live && rA_address != '0 && w_ent.rd_addr == rA_address) ? w_mask : '0;
    assign w_b_mask = (w_live && rB_address != '0 && w_ent.rd_addr == rB_address) ? w_mask : '0;

    if (gi == 0) begin : g_first
      assign w_a_base = rA_rf_data;
      assign w_b_base = rB_rf_data;
    end else begin : g_next
      assign w_a_base = g_fwd[gi-1].w_a_out;
      assign w_b_base = g_fwd[gi-1].w_b_out;
    end

    wb_byte_merge u_merge_a (
      .i_base  (w_a_base),
      .i_new   (w_ent.data),
      .i_mask  (w_a_mask),
      .o_merged(w_a_out)
    );

    wb_byte_merge u_merge_b (
      .i_base  (w_b_base),
      .i_new   (w_ent.data),
      .i_mask  (w_b_mask),
      .o_merged(w_b_out)
    );
  end

  assign rA_fwd_data = g_fwd[DEPTH-1].w_a_out;
  assign rB_fwd_data = g_fwd[DEPTH-1].w_b_out;
`else
  // Without forwarding, issue must stall on pending; operands pass straight through.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{rA_address, rB_address};
  assign rA_fwd_data  = rA_rf_data;
  assign rB_fwd_data  = rB_rf_data;
`endif

endmodule
